// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: status encodings,
// default start address and the status classification helper.
package instruction_fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_STALL = 2'd2
  } fetch_state_e;

  localparam int DEFAULT_RESET_PC = 0;

  // Status is derived from the datapath, never the other way round.
  function automatic fetch_state_e classify_state(input logic pend_valid,
                                                  input logic instr_valid,
                                                  input logic stall);
    fetch_state_e st;
    if (stall) begin
      st = ST_STALL;
    end else if (!pend_valid && !instr_valid) begin
      st = ST_IDLE;
    end else begin
      st = ST_FETCH;
    end
    return st;
  endfunction

endpackage

// File: rtl/instruction_fetch_pc_register.sv
// Fetch program counter: async reset to the start address, branch load,
// hold, and modulo-2^AddressWidth increment.
module instruction_fetch_pc_register #(
  parameter int AddressWidth = 4,
  parameter int ResetPC      = 0,
  parameter int PCStep       = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic                    inc,
  input  logic [AddressWidth-1:0] load_value,
  output logic [AddressWidth-1:0] pc
);

  localparam logic [AddressWidth-1:0] RESET_VALUE = AddressWidth'(ResetPC);
  localparam logic [AddressWidth-1:0] STEP_VALUE  = AddressWidth'(PCStep);

  logic [AddressWidth-1:0] pc_r;

  // PC update; the add wraps silently at the top of the address space
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_r <= RESET_VALUE;
    end else if (load) begin
      pc_r <= load_value;
    end else if (inc) begin
      pc_r <= pc_r + STEP_VALUE;
    end else begin
      pc_r <= pc_r;
    end
  end

  assign pc = pc_r;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage in front of a one-cycle-latency word memory:
// issues addresses, captures read data and hands it to decode via valid/ready.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int WordSize     = 32,
  parameter int AddressWidth = 4,
  parameter int ResetPC      = DEFAULT_RESET_PC,
  parameter int PCStep       = 1
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic                    Enable,
  output logic [AddressWidth-1:0] MemAddress,
  output logic                    MemStatus,
  input  logic [WordSize-1:0]     MemQ,
  input  logic                    BranchTaken,
  input  logic [AddressWidth-1:0] BranchTarget,
  input  logic                    OutReady,
  output logic [WordSize-1:0]     Instruction,
  output logic [AddressWidth-1:0] InstrPC,
  output logic                    InstrValid,
  output fetch_state_e            FetchState
);

  logic [AddressWidth-1:0] fetch_pc_s;
  logic [AddressWidth-1:0] pend_pc_r,     pend_pc_s;
  logic                    pend_valid_r,  pend_valid_s;
  logic [WordSize-1:0]     instruction_r, instruction_s;
  logic [AddressWidth-1:0] instr_pc_r,    instr_pc_s;
  logic                    instr_valid_r, instr_valid_s;
  fetch_state_e            state_r,       state_s;
  logic                    stall_s;
  logic                    pc_inc_s;

  assign stall_s  = pend_valid_r & instr_valid_r & ~OutReady & ~BranchTaken;
  assign pc_inc_s = Enable & ~BranchTaken & ~stall_s;

  // Replaying the pending address keeps MemQ valid for the held word
  assign MemAddress = stall_s ? pend_pc_r : fetch_pc_s;
  assign MemStatus  = 1'b0;

  instruction_fetch_pc_register #(
    .AddressWidth (AddressWidth),
    .ResetPC      (ResetPC),
    .PCStep       (PCStep)
  ) u_pc (
    .clk        (Clock),
    .rst        (Reset),
    .load       (BranchTaken),
    .inc        (pc_inc_s),
    .load_value (BranchTarget),
    .pc         (fetch_pc_s)
  );

  // Next-state for pending slot, output register and status
  always_comb begin
    pend_pc_s     = pend_pc_r;
    pend_valid_s  = pend_valid_r;
    instruction_s = instruction_r;
    instr_pc_s    = instr_pc_r;
    instr_valid_s = instr_valid_r;
    if (BranchTaken) begin
      pend_valid_s  = 1'b0;
      instr_valid_s = 1'b0;
    end else if (stall_s) begin
      pend_valid_s  = pend_valid_r;
    end else begin
      if (pend_valid_r) begin
        instruction_s = MemQ;
        instr_pc_s    = pend_pc_r;
        instr_valid_s = 1'b1;
      end else if (OutReady) begin
        instr_valid_s = 1'b0;
      end else begin
        instr_valid_s = instr_valid_r;
      end
      if (Enable) begin
        pend_pc_s    = fetch_pc_s;
        pend_valid_s = 1'b1;
      end else begin
        pend_valid_s = 1'b0;
      end
    end
    state_s = classify_state(pend_valid_s, instr_valid_s, stall_s);
  end

  // Pipeline registers; status reflects the decision taken at the last edge
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      pend_pc_r     <= '0;
      pend_valid_r  <= 1'b0;
      instruction_r <= '0;
      instr_pc_r    <= '0;
      instr_valid_r <= 1'b0;
      state_r       <= ST_IDLE;
    end else begin
      pend_pc_r     <= pend_pc_s;
      pend_valid_r  <= pend_valid_s;
      instruction_r <= instruction_s;
      instr_pc_r    <= instr_pc_s;
      instr_valid_r <= instr_valid_s;
      state_r       <= state_s;
    end
  end

  assign Instruction = instruction_r;
  assign InstrPC     = instr_pc_r;
  assign InstrValid  = instr_valid_r;
  assign FetchState  = state_r;

endmodule
